// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among four byte
// requesters. The transmitter has no busy output, so this block times each
// frame itself and inserts one idle cycle before the next grant. That idle
// cycle keeps the send enable low between frames, so every frame starts on a
// fresh rising edge.
module uart_tx_arbiter #(
   parameter int FRAME_CYCLES = 270,
   parameter int NUM_REQ      = 4
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   output logic [3:0]  ack,
   output logic        uart_send,
   output logic [7:0]  uart_data_out,
   output logic        busy,
   output logic [1:0]  grant_id
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam logic [9:0] WAIT_LOAD = 10'(FRAME_CYCLES - 1);

   logic [1:0] r_state;
   logic [9:0] r_count;
   logic [1:0] r_ptr;
   logic [3:0] r_ack;
   logic       r_send;
   logic [7:0] r_data;
   logic       r_busy;
   logic [1:0] r_grant;

   logic       w_found;
   logic [1:0] w_winner;
   logic [7:0] w_winByte;

   // Find the first active request, scanning upward from the pointer and wrapping
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_ptr;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!w_found && req[r_ptr + 2'(j)]) begin
            w_found  = 1'b1;
            w_winner = r_ptr + 2'(j);
         end
      end
   end

   assign w_winByte = req_data[{w_winner, 3'b000} +: 8];

   // Grant, one-cycle send pulse, then count out the frame before returning to idle
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
         r_count <= 10'd0;
         r_ptr   <= 2'd0;
         r_ack   <= 4'b0000;
         r_send  <= 1'b0;
         r_data  <= 8'h00;
         r_busy  <= 1'b0;
         r_grant <= 2'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ack  <= 4'b0000;
               r_send <= 1'b0;
               if (w_found) begin
                  r_state <= ST_SEND;
                  r_send  <= 1'b1;
                  r_data  <= w_winByte;
                  r_ack   <= 4'b0001 << w_winner;
                  r_grant <= w_winner;
                  r_busy  <= 1'b1;
                  r_ptr   <= w_winner + 2'd1;
               end
            end
            ST_SEND: begin
               r_send  <= 1'b0;
               r_ack   <= 4'b0000;
               r_count <= WAIT_LOAD;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_count == 10'd0) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_data  <= 8'h00;
               end else begin
                  r_count <= r_count - 10'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ack   <= 4'b0000;
               r_send  <= 1'b0;
               r_data  <= 8'h00;
               r_busy  <= 1'b0;
               r_count <= 10'd0;
            end
         endcase
      end
   end

   assign ack           = r_ack;
   assign uart_send     = r_send;
   assign uart_data_out = r_data;
   assign busy          = r_busy;
   assign grant_id      = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus a randomized run,
// checked against a transaction-level model of the arbiter. It also includes
// a behavioural transmitter and a receiver that loop the bytes back.
module tb_uart_tx_arbiter;

   localparam int FRAME = 270;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b1;
   logic [3:0]  req       = 4'b0000;
   logic [31:0] req_data  = 32'h0;
   logic [3:0]  ack;
   logic        uart_send;
   logic [7:0]  uart_data_out;
   logic        busy;
   logic [1:0]  grant_id;

   uart_tx_arbiter #(.FRAME_CYCLES(FRAME), .NUM_REQ(4)) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .req           (req),
      .req_data      (req_data),
      .ack           (ack),
      .uart_send     (uart_send),
      .uart_data_out (uart_data_out),
      .busy          (busy),
      .grant_id      (grant_id)
   );

   // 50 MHz system clock
   always #10 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   // Model state: grant timing and arbitration pointer at transaction level
   int         edgeNo;
   int         lastGrant;
   int         mPtr;
   logic [1:0] mGrant;
   logic [7:0] mByte;
   logic [7:0] rxQ[$];

   // Observations of the DUT used by the directed scenarios
   int   obsGrants[$];
   int   obsLastSend;
   logic obsPrevSend;
   bit   spacingOn = 1'b0;
   int   busyCount = 0;
   int   ackOdd    = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      edgeNo      = 0;
      lastGrant   = -1000;
      mPtr        = 0;
      mGrant      = 2'd0;
      mByte       = 8'h00;
      rxQ.delete();
      obsGrants.delete();
      obsLastSend = -1;
      obsPrevSend = 1'b0;
   endtask

   function automatic bit modelSamplesNext();
      return (edgeNo + 1) >= (lastGrant + FRAME + 2);
   endfunction

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ack"},  {28'h0, ack}, 32'h0);
      checkOutput({tag, "_send"}, {31'h0, uart_send}, 32'h0);
      checkOutput({tag, "_data"}, {24'h0, uart_data_out}, 32'h0);
      checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
      checkOutput({tag, "_gid"},  {30'h0, grant_id}, 32'h0);
   endtask

   // One clock edge: advance the model with the driven inputs, then compare outputs
   task automatic clockAndCheck();
      bit         found;
      int         w;
      logic       expSend, expBusy;
      logic [3:0] expAck;
      logic [7:0] expData;
      @(posedge sys_clk);
      edgeNo++;
      found = 1'b0;
      if (edgeNo >= lastGrant + FRAME + 2 && req != 4'b0000) begin
         for (int j = 0; j < 4; j++) begin
            w = (mPtr + j) % 4;
            if (!found && req[w]) begin
               found     = 1'b1;
               mGrant    = 2'(w);
               mByte     = req_data[8*w +: 8];
               mPtr      = (w + 1) % 4;
               lastGrant = edgeNo;
               rxQ.push_back(mByte);
            end
         end
      end
      expSend = (edgeNo == lastGrant);
      expAck  = expSend ? (4'b0001 << mGrant) : 4'b0000;
      expBusy = (edgeNo >= lastGrant) && (edgeNo <= lastGrant + FRAME);
      expData = expBusy ? mByte : 8'h00;
      #1;
      checkOutput("send", {31'h0, uart_send}, {31'h0, expSend});
      checkOutput("ack",  {28'h0, ack}, {28'h0, expAck});
      checkOutput("busy", {31'h0, busy}, {31'h0, expBusy});
      checkOutput("data", {24'h0, uart_data_out}, {24'h0, expData});
      checkOutput("gid",  {30'h0, grant_id}, {30'h0, mGrant});
      if (busy) busyCount++;
      if ((ack & 4'b1010) != 4'b0000) ackOdd++;
      if (uart_send && !obsPrevSend) begin
         obsGrants.push_back(int'(grant_id));
         if (spacingOn && obsLastSend >= 0)
            checkOutput("spacing", 32'(edgeNo - obsLastSend), 32'(FRAME + 2));
         obsLastSend = edgeNo;
      end
      obsPrevSend = uart_send;
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
      @(negedge sys_clk);
      req      = r;
      req_data = d;
      clockAndCheck();
   endtask

   task automatic releaseAndApply(input logic [3:0] r, input logic [31:0] d);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      req       = r;
      req_data  = d;
      clockAndCheck();
   endtask

   task automatic pulseReset(input string tag);
      #5;
      sys_rst_n = 1'b0;
      #1;
      checkResetOutputs(tag);
      modelReset();
   endtask

   task automatic settle();
      repeat (FRAME + 2) applyStimulus(4'b0000, 32'h0);
   endtask

   // Behavioural transmitter: 25 clocks per bit, start on the rising edge of send
   logic       txLine = 1'b1;
   int         txBit  = -1;
   int         txCnt  = 0;
   logic [9:0] txShift = 10'h3FF;
   logic       sendPrev = 1'b0;
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         txLine   <= 1'b1;
         txBit    <= -1;
         txCnt    <= 0;
         sendPrev <= 1'b0;
      end else begin
         sendPrev <= uart_send;
         if (uart_send && !sendPrev && txBit < 0) begin
            txShift <= {1'b1, uart_data_out, 1'b0};
            txBit   <= 0;
            txCnt   <= 0;
            txLine  <= 1'b0;
         end else if (txBit >= 0) begin
            if (txCnt == 24) begin
               txCnt <= 0;
               if (txBit == 9) begin
                  txBit  <= -1;
                  txLine <= 1'b1;
               end else begin
                  txBit  <= txBit + 1;
                  txLine <= txShift[txBit + 1];
               end
            end else begin
               txCnt <= txCnt + 1;
            end
         end
      end
   end

   // Receiver: sample mid-bit, then compare each byte with the model's grant order
   logic       rxActive = 1'b0;
   int         rxCnt    = 0;
   logic [9:0] rxBits   = 10'h0;
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rxActive <= 1'b0;
         rxCnt    <= 0;
      end else if (!rxActive) begin
         if (!txLine) begin
            rxActive <= 1'b1;
            rxCnt    <= 1;
         end
      end else begin
         rxCnt <= rxCnt + 1;
         if (rxCnt % 25 == 12 && rxCnt < 237) rxBits[rxCnt / 25] <= txLine;
         if (rxCnt == 237) begin
            rxActive <= 1'b0;
            checkOutput("rxFraming", {30'h0, txLine, rxBits[0]}, 32'h2);
            if (rxQ.size() == 0) checkOutput("rxUnexpected", {24'h0, rxBits[8:1]}, 32'h100);
            else checkOutput("rxByte", {24'h0, rxBits[8:1]}, {24'h0, rxQ.pop_front()});
         end
      end
   end

   // Global time bound
   initial begin
      #(64'd2_500_000);
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] timeout");
   end

   // Directed scenarios followed by a randomized run
   initial begin
      int         exp2[5];
      int         exp3[4];
      logic [3:0] pend;
      logic [7:0] pbyte[4];
      logic [3:0] r;
      logic [31:0] d;
      int         generated;
      int         cyc;
      exp2 = '{0, 1, 2, 3, 0};
      exp3 = '{0, 2, 0, 2};

      #1 sys_rst_n = 1'b0;
      #2 checkResetOutputs("reset");
      modelReset();

      // Scenario 1: single request right after reset
      busyCount = 0;
      releaseAndApply(4'b0001, 32'h0000_0055);
      checkOutput("t1Ack", {28'h0, ack}, 32'h1);
      checkOutput("t1Data", {24'h0, uart_data_out}, 32'h55);
      repeat (FRAME + 4) applyStimulus(4'b0000, 32'h0);
      checkOutput("t1BusyLen", 32'(busyCount), 32'(FRAME + 1));

      // Scenario 2: all four held, full rotation with fixed spacing
      pulseReset("t2Reset");
      spacingOn = 1'b1;
      releaseAndApply(4'b1111, 32'h4433_2211);
      repeat (1099) applyStimulus(4'b1111, 32'h4433_2211);
      spacingOn = 1'b0;
      checkOutput("t2Count", 32'(obsGrants.size()), 32'd5);
      for (int i = 0; i < 5 && i < obsGrants.size(); i++)
         checkOutput($sformatf("t2Grant%0d", i), 32'(obsGrants[i]), 32'(exp2[i]));
      settle();

      // Scenario 3: requesters 0 and 2 held continuously
      pulseReset("t3Reset");
      ackOdd    = 0;
      spacingOn = 1'b1;
      releaseAndApply(4'b0101, 32'h00CC_00AA);
      repeat (829) applyStimulus(4'b0101, 32'h00CC_00AA);
      spacingOn = 1'b0;
      checkOutput("t3Count", 32'(obsGrants.size()), 32'd4);
      for (int i = 0; i < 4 && i < obsGrants.size(); i++)
         checkOutput($sformatf("t3Grant%0d", i), 32'(obsGrants[i]), 32'(exp3[i]));
      checkOutput("t3OddAcks", 32'(ackOdd), 32'd0);
      settle();

      // Scenario 4: short request pulse during the wait period is ignored
      obsGrants.delete();
      applyStimulus(4'b0001, 32'h0000_00E1);
      repeat (49) applyStimulus(4'b0000, 32'h0);
      applyStimulus(4'b0010, 32'h0000_BB00);
      repeat (FRAME) applyStimulus(4'b0000, 32'h0);
      checkOutput("t4Sends", 32'(obsGrants.size()), 32'd1);

      // Scenario 5: reset mid-wait, then request 3 wins from pointer 0
      applyStimulus(4'b0001, 32'h0000_0077);
      repeat (170) applyStimulus(4'b0000, 32'h0);
      pulseReset("t5Reset");
      releaseAndApply(4'b1000, 32'h9900_0000);
      checkOutput("t5Ack", {28'h0, ack}, 32'h8);
      checkOutput("t5Gid", {30'h0, grant_id}, 32'h3);
      settle();

      // Scenario 6: 100 random bytes on random requesters, with ignored noise while busy
      pend      = 4'b0000;
      generated = 0;
      cyc       = 0;
      for (int i = 0; i < 4; i++) pbyte[i] = 8'h00;
      while ((generated < 100 || pend != 4'b0000) && cyc < 50000) begin
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && generated < 100 && $urandom_range(0, 39) == 0) begin
               pend[i]  = 1'b1;
               pbyte[i] = 8'($urandom);
               generated++;
            end
         end
         r = pend;
         for (int i = 0; i < 4; i++) d[8*i +: 8] = pend[i] ? pbyte[i] : 8'($urandom);
         if (!modelSamplesNext()) r = r | 4'($urandom_range(0, 15));
         applyStimulus(r, d);
         if (lastGrant == edgeNo) pend[mGrant] = 1'b0;
         cyc++;
      end
      checkOutput("t6Budget", {31'h0, cyc >= 50000}, 32'h0);
      settle();
      checkOutput("rxLeft", 32'(rxQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
